uart_tx_arbiter: RTL
====================

# uart_tx_arbiter

Shares the single UART transmit path among N_REQ byte-stream requesters by round-robin arbitration. Each granted stream is wrapped in a frame (header byte, payload, XOR checksum byte) and written one byte per cycle into the UART controller's TX FIFO write port (`w_en`/`data_in`/`full`), in the system clock domain. Sits between on-chip message sources and the UART controller.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `MAX_PAYLOAD`, 16: maximum payload bytes per frame, 1..255.
- `SOF`, 4'hA: start-of-frame nibble in the header byte.

Ports:
- `clk`  in  1  system clock. Same clock as the UART controller write side.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  N_REQ  per-requester byte valid.
- `req_data`  in  8*N_REQ  per-requester byte; requester i uses bits [8i+7:8i].
- `req_last`  in  N_REQ  marks the final payload byte of a message.
- `req_ready`  out  N_REQ  byte accepted when `req_valid[i] && req_ready[i]`.
- `fifo_full`  in  1  TX FIFO full.
- `fifo_w_en`  out  1  TX FIFO write strobe.
- `fifo_data`  out  8  TX FIFO write data.
- `busy`  out  1  high in any state other than IDLE.
- `grant_id`  out  3  index of the current or last granted requester.
- `overflow_err`  out  1  one-cycle pulse when a frame is truncated at MAX_PAYLOAD.

## Operation
- FSM states: IDLE, HDR, PAYLOAD, CSUM.
- **IDLE**
  - If any `req_valid` is high, select a winner by round-robin, starting from requester `rr_ptr` and searching upward with wrap.
  - Register the winner into `grant_id`, clear `count`, go to HDR.
- **HDR**
  - Header = {SOF, 1'b0, grant_id[2:0]}.
  - When `!fifo_full`: write the header, set `csum` = header, go to PAYLOAD.
- **PAYLOAD**
  - `req_ready[g] = !fifo_full`. All other `req_ready` bits are 0.
  - On a handshake: write `req_data[g]`, `csum ^= byte`, `count++`.
  - Go to CSUM on a handshake with `req_last[g]`, or on the handshake that makes `count == MAX_PAYLOAD`.
  - If that final handshake lacks `req_last`, pulse `overflow_err`. The requester's remaining bytes go out in a later frame.
  - If `req_valid[g]` drops, the grant is held indefinitely (no timeout). Other requests are ignored while busy.
- **CSUM**
  - When `!fifo_full`: write `csum`, set `rr_ptr = (g+1) mod N_REQ`, go to IDLE.
- An empty payload is impossible: at least one byte with `req_last` always ends the payload.
- `fifo_w_en` is combinational:
  - HDR or CSUM: asserted when `!fifo_full`.
  - PAYLOAD: asserted when `req_valid[g] && !fifo_full`.
  - It is never asserted while `fifo_full` is high.
- `fifo_data` is muxed from the header, `req_data[g]` or `csum` by state. It is 0 in IDLE.

## Timing
- Reset values:
  - State IDLE; `rr_ptr` 0, so requester 0 has priority first.
  - `grant_id` 0, `csum` 0, `count` 0.
  - `busy` 0, `overflow_err` 0, `req_ready` all 0, `fifo_w_en` 0, `fifo_data` 0.
- Latency and throughput:
  - `req_valid` rising in IDLE at cycle t: HDR is entered at t+1, and the header is written at t+1 if the FIFO is not full.
  - First payload byte is accepted at t+2 at the earliest.
  - Frame of L bytes with no backpressure: L+2 write cycles, plus 1 IDLE cycle between frames.
- Backpressure: `fifo_full` stalls any state in place; no byte is lost or duplicated.
- Simultaneous requests: the winner is the first valid requester at or after `rr_ptr`. With all requesters valid continuously, grants rotate 0,1,2,3,0…
- `req_last` on byte MAX_PAYLOAD: normal end, no `overflow_err`.
- `rst` mid-frame: return to IDLE the next cycle. The partial frame is abandoned with no checksum; the receiver resyncs on SOF.
- `count` width is 8 bits; it never wraps because the FSM leaves PAYLOAD at MAX_PAYLOAD.

## Structure
- Package `uart_arb_pkg` holds:
  - the state enum (IDLE/HDR/PAYLOAD/CSUM);
  - the default SOF constant;
  - a header-builder function (SOF, id → byte).
- One sub-module, `rr_arbiter`: combinational round-robin pick of a one-hot grant and index from `req_valid` and `rr_ptr`. Pointer update stays in the parent FSM.

## Test plan
- **Single short frame.** After reset, requester 2 sends 0x11, 0x22 (last), FIFO never full. Expect writes 0xA2, 0x11, 0x22, 0xA2^0x11^0x22 = 0x91 on consecutive cycles, `busy` falling after CSUM.
- **Contention.** All four requesters send 1-byte frames continuously. Grant order is 0,1,2,3,0; each header carries the matching id.
- **Backpressure.** `fifo_full` is forced high for 5 cycles mid-payload. `fifo_w_en` and `req_ready` stay 0 for those cycles; the byte stream resumes unchanged with no loss or duplicate.
- **Truncation.** MAX_PAYLOAD=4; requester 1 sends 6 bytes. Expect frame 1 with 4 bytes and a single `overflow_err` pulse, then a second frame with the remaining 2 bytes and no error.
- **Reset mid-frame.** `rst` is asserted after 2 payload bytes. Next cycle: IDLE, all outputs at reset values, no checksum written; the next request is granted starting from requester 0.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_PAYLOAD,
        ST_CSUM
    } arb_state_e;

    localparam logic [3:0] SOF_DEFAULT = 4'hA;

    // Frame header: start-of-frame nibble, a zero bit, then the requester id.
    function automatic logic [7:0] build_header(input logic [3:0] sof, input logic [2:0] id);
        return {sof, 1'b0, id};
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first valid requester at or after rr_ptr_i, wrapping.
module rr_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0] req_valid_i,
    input  logic [2:0]       rr_ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [2:0]       gnt_id_o
);

    logic [2:0]       cand;
    logic [N_REQ-1:0] cand_req;

    // Walk candidates upward from the pointer; the first valid one wins.
    always_comb begin
        gnt_o    = '0;
        gnt_id_o = '0;
        cand     = '0;
        cand_req = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand     = 3'((32'(rr_ptr_i) + k) % N_REQ);
            cand_req = req_valid_i >> cand;
            if (gnt_o == '0 && cand_req[0]) begin
                gnt_o    = N_REQ'(1) << cand;
                gnt_id_o = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of the UART TX FIFO write port; each grant is framed as
// header, payload bytes and an XOR checksum byte.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int         N_REQ       = 4,
    parameter int         MAX_PAYLOAD = 16,
    parameter logic [3:0] SOF         = SOF_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [8*N_REQ-1:0]   req_data,
    input  logic [N_REQ-1:0]     req_last,
    output logic [N_REQ-1:0]     req_ready,
    input  logic                 fifo_full,
    output logic                 fifo_w_en,
    output logic [7:0]           fifo_data,
    output logic                 busy,
    output logic [2:0]           grant_id,
    output logic                 overflow_err
);

    arb_state_e       state_q, state_d;
    logic [2:0]       grant_q, grant_d;
    logic [2:0]       rr_ptr_q, rr_ptr_d;
    logic [7:0]       csum_q, csum_d;
    logic [7:0]       count_q, count_d;

    logic [N_REQ-1:0] arb_gnt;
    logic [2:0]       arb_id;
    logic [7:0]       g_data;
    logic             g_valid;
    logic             g_last;
    logic [7:0]       hdr;
    logic             final_beat;

    rr_arbiter #(
        .N_REQ(N_REQ)
    ) u_rr_arbiter (
        .req_valid_i(req_valid),
        .rr_ptr_i   (rr_ptr_q),
        .gnt_o      (arb_gnt),
        .gnt_id_o   (arb_id)
    );

    assign hdr        = build_header(SOF, grant_q);
    assign final_beat = (count_q + 8'd1) == 8'(MAX_PAYLOAD);
    assign busy       = (state_q != ST_IDLE);
    assign grant_id   = grant_q;

    // Select the granted requester's byte, valid and last.
    always_comb begin
        g_data  = '0;
        g_valid = 1'b0;
        g_last  = 1'b0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (grant_q == 3'(k)) begin
                g_data  = req_data[8*k +: 8];
                g_valid = req_valid[k];
                g_last  = req_last[k];
            end
        end
    end

    // Next-state, FIFO write strobe/data, ready and overflow pulse.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        rr_ptr_d     = rr_ptr_q;
        csum_d       = csum_q;
        count_d      = count_q;
        fifo_w_en    = 1'b0;
        fifo_data    = '0;
        req_ready    = '0;
        overflow_err = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (arb_gnt != '0) begin
                    grant_d = arb_id;
                    count_d = '0;
                    state_d = ST_HDR;
                end
            end
            ST_HDR: begin
                fifo_data = hdr;
                if (!fifo_full) begin
                    fifo_w_en = 1'b1;
                    csum_d    = hdr;
                    state_d   = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                fifo_data = g_data;
                if (!fifo_full) begin
                    for (int unsigned k = 0; k < N_REQ; k++) begin
                        req_ready[k] = (grant_q == 3'(k));
                    end
                    if (g_valid) begin
                        fifo_w_en = 1'b1;
                        csum_d    = csum_q ^ g_data;
                        count_d   = count_q + 8'd1;
                        if (g_last) begin
                            state_d = ST_CSUM;
                        end else if (final_beat) begin
                            state_d      = ST_CSUM;
                            overflow_err = 1'b1;
                        end
                    end
                end
            end
            ST_CSUM: begin
                fifo_data = csum_q;
                if (!fifo_full) begin
                    fifo_w_en = 1'b1;
                    rr_ptr_d  = (grant_q == 3'(N_REQ - 1)) ? 3'd0 : grant_q + 3'd1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            csum_q   <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            csum_q   <= csum_d;
            count_q  <= count_d;
        end
    end

endmodule
